// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and the 2-cycle ALU: RAW scoreboard, branch hold, redirect.
// Optional ALU_ISSUE_PERF_EN adds saturating stall/hazard/branch counters.
module alu_issue_ctrl #(
    parameter int cRegSelBitW = 5,
    parameter int cXLEN       = 32,
    parameter int PEND_DEPTH  = 3,
    parameter int BR_LAT      = 2
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic [cRegSelBitW-1:0] iRs1Addr,
    input  logic [cRegSelBitW-1:0] iRs2Addr,
    input  logic                   iUseRs1,
    input  logic                   iUseRs2,
    input  logic [cRegSelBitW-1:0] iRdAddr,
    input  logic                   iWrRd,
    input  logic                   iIsReg,
    input  logic                   iIsMem,
    input  logic                   iIsBranch,
    output logic                   oRegDv,
    output logic                   oMemDv,
    output logic                   oBranchDv,
    input  logic                   iBranchDv,
    input  logic                   iBranchTaken,
    input  logic [cXLEN-1:0]       iBranchAddr,
    output logic                   oRedirect,
    output logic [cXLEN-1:0]       oRedirectAddr,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]            oStallCnt,
    output logic [31:0]            oHazardCnt,
    output logic [31:0]            oBranchCnt,
`endif
    output logic                   oBusy
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam int cCntW = $clog2(BR_LAT + 1);

    state_t                  r_state;
    logic [cCntW-1:0]        r_brCnt;
    logic [cXLEN-1:0]        r_redirAddr;
    logic [PEND_DEPTH-1:0]   r_sbValid;
    logic [cRegSelBitW-1:0]  r_sbRd [PEND_DEPTH];

    logic w_hazard;
    logic w_ready;
    logic w_issue;
    logic w_load;

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (r_sbValid[i]) begin
                if (iUseRs1 && (iRs1Addr != '0) && (iRs1Addr == r_sbRd[i]))
                    w_hazard = 1'b1;
                if (iUseRs2 && (iRs2Addr != '0) && (iRs2Addr == r_sbRd[i]))
                    w_hazard = 1'b1;
            end
        end
    end

    assign w_ready   = (r_state == RUN) && !w_hazard && iRst;
    assign w_issue   = iValid && w_ready;
    assign w_load    = w_issue && iWrRd && (iRdAddr != '0);

    assign oReady        = w_ready;
    assign oRegDv        = w_issue && iIsReg;
    assign oMemDv        = w_issue && iIsMem;
    assign oBranchDv     = w_issue && iIsBranch;
    assign oRedirect     = (r_state == REDIRECT);
    assign oRedirectAddr = r_redirAddr;
    assign oBusy         = (|r_sbValid) || (r_state != RUN);

    // Fixed-latency window: entries age out after PEND_DEPTH cycles
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_sbValid <= '0;
            for (int i = 0; i < PEND_DEPTH; i++)
                r_sbRd[i] <= '0;
        end else begin
            for (int i = PEND_DEPTH - 1; i > 0; i--) begin
                r_sbValid[i] <= r_sbValid[i-1];
                r_sbRd[i]    <= r_sbRd[i-1];
            end
            r_sbValid[0] <= w_load;
            r_sbRd[0]    <= iRdAddr;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state     <= RUN;
            r_brCnt     <= '0;
            r_redirAddr <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_issue && iIsBranch) begin
                        r_state <= BR_WAIT;
                        r_brCnt <= cCntW'(BR_LAT);
                    end
                end
                BR_WAIT: begin
                    if (r_brCnt != '0)
                        r_brCnt <= r_brCnt - 1'b1;
                    if (iBranchDv) begin
                        if (iBranchTaken) begin
                            r_state     <= REDIRECT;
                            r_redirAddr <= iBranchAddr;
                        end else begin
                            r_state <= RUN;
                        end
                        r_brCnt <= '0;
                    end else if (r_brCnt <= cCntW'(1)) begin
                        // No result within the window: resume as not taken
                        r_state <= RUN;
                    end
                end
                REDIRECT: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_hazardCnt;
    logic [31:0] r_branchCnt;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_stallCnt  <= '0;
            r_hazardCnt <= '0;
            r_branchCnt <= '0;
        end else begin
            if (iValid && !w_ready && (r_stallCnt != '1))
                r_stallCnt <= r_stallCnt + 32'd1;
            if (iValid && w_hazard && (r_state == RUN) && (r_hazardCnt != '1))
                r_hazardCnt <= r_hazardCnt + 32'd1;
            if ((r_state == REDIRECT) && (r_branchCnt != '1))
                r_branchCnt <= r_branchCnt + 32'd1;
        end
    end

    assign oStallCnt  = r_stallCnt;
    assign oHazardCnt = r_hazardCnt;
    assign oBranchCnt = r_branchCnt;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue controller between the decode stage and the 2-cycle ALU.
- Accepts decoded ops over a valid/ready handshake and gates the ALU data-valid strobes (reg, mem and branch dv).
- Stalls read-after-write hazards against in-flight register writes using a shift-register scoreboard.
- Holds issue while a branch is unresolved, then pulses a redirect or resumes.

Parameters:
- cRegSelBitW, 5: register address width.
- cXLEN, 32: data/address width.
- PEND_DEPTH, 3: scoreboard depth in cycles. Covers ALU latency 2 plus 1 writeback cycle.
- BR_LAT, 2: cycles from branch issue to valid iBranchDv.

Ports:
- iClk  in  1  clock, rising edge
- iRst  in  1  asynchronous reset, active-low
- iValid  in  1  decoded op available
- oReady  out  1  controller accepts op this cycle
- iRs1Addr  in  cRegSelBitW  source 1 address
- iRs2Addr  in  cRegSelBitW  source 2 address
- iUseRs1  in  1  op reads rs1
- iUseRs2  in  1  op reads rs2
- iRdAddr  in  cRegSelBitW  destination address
- iWrRd  in  1  op writes rd (reg ops, loads, jal/jalr)
- iIsReg  in  1  op class reg; ops may be multi-class
- iIsMem  in  1  op class mem; ops may be multi-class
- iIsBranch  in  1  op class branch; ops may be multi-class
- oRegDv  out  1  gated reg dv to ALU
- oMemDv  out  1  gated mem dv to ALU
- oBranchDv  out  1  gated branch dv to ALU
- iBranchDv  in  1  ALU branch result valid
- iBranchTaken  in  1  ALU branch taken
- iBranchAddr  in  cXLEN  ALU branch target
- oRedirect  out  1  one-cycle fetch redirect pulse
- oRedirectAddr  out  cXLEN  redirect target
- oBusy  out  1  any scoreboard entry valid or state not RUN

Behaviour:
- Handshake:
  - issue = iValid & oReady.
  - oReady is combinational: state==RUN & ~hazard & iRst.
  - oRegDv = issue & iIsReg. oMemDv and oBranchDv are formed the same way. All three are combinational, same cycle.
- Hazard:
  - Asserted if any valid scoreboard entry e satisfies (iUseRs1 & iRs1Addr==e.rd) | (iUseRs2 & iRs2Addr==e.rd).
  - Addresses equal to 0 never match.
- Scoreboard:
  - PEND_DEPTH entries of {valid, rd}.
  - Shifts one position every cycle; the oldest entry is dropped.
  - Entry 0 loads {issue & iWrRd & (iRdAddr!=0), iRdAddr}.
  - An op issued at cycle T blocks dependents through T+PEND_DEPTH; the dependent issues at T+PEND_DEPTH+1.
- FSM states: RUN, BR_WAIT, REDIRECT.
  - RUN: issue with iIsBranch -> BR_WAIT and load brCnt=BR_LAT.
  - BR_WAIT: oReady=0; brCnt decrements each cycle. On iBranchDv: taken -> REDIRECT; not taken -> RUN.
  - BR_WAIT timeout: if brCnt reaches 0 without iBranchDv -> RUN, treated as not taken.
  - iBranchDv outside BR_WAIT is ignored.
  - REDIRECT: oRedirect=1 and oRedirectAddr=target registered at iBranchDv, for exactly one cycle; oReady=0; next state RUN.
- Scoreboard entries from a jal/jalr rd write stay valid through the redirect; they are not flushed.
- Simultaneous iBranchDv and a hazard: the FSM transition takes priority. Hazard affects only oReady in RUN.
- Reset (async assert, sync-safe release):
  - State RUN, scoreboard cleared, brCnt 0.
  - oRedirect=0, oRedirectAddr=0, oBusy=0.
  - oReady and all dv outputs are 0 while iRst is low.
  - Reset mid-branch discards the pending branch; no redirect is issued.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined, adds the following outputs:
  - oStallCnt[31:0]: increments each cycle iValid & ~oReady.
  - oHazardCnt[31:0]: increments each cycle iValid & hazard & state==RUN.
  - oBranchCnt[31:0]: increments per taken redirect.
- Counters saturate at all-ones and clear on reset.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with iValid=1 and independent ops (iWrRd=1, rd=1..8 sequentially) -> issue every cycle; oRegDv high each cycle; oBusy=1.
- Issue add rd=5, then next cycle op with iUseRs1=1, rs1=5 -> oReady=0 for 3 cycles; issue on the 4th cycle after the producer (T+4).
- Producer rd=0, consumer rs1=0 -> no stall; back-to-back issue.
- Branch issued at T with iBranchDv=1, iBranchTaken=1, iBranchAddr=0x100 at T+2 -> oReady=0 at T+1..T+3; oRedirect=1 with addr 0x100 at T+3; oReady=1 at T+4.
- Branch issued, iBranchDv never asserted -> return to RUN after BR_LAT cycles with no oRedirect pulse.
- iRst driven low during BR_WAIT, then released -> state RUN, no oRedirect, scoreboard empty, dependent op issues immediately. With ALU_ISSUE_PERF_EN, oStallCnt=0 after reset.
